// File: rtl/adc_avg_sequencer.sv
// Paces SAR ADC conversions, averages 2**LOG2_AVG captured results and hands each
// average to the back end through a single-entry valid/ready output register.
module adc_avg_sequencer #(
    parameter int RESOLUTION = 8,
    parameter int LOG2_AVG   = 2,
    parameter int PERIOD_W   = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [PERIOD_W-1:0]   period_i,
    input  logic                  clr_status_i,
    output logic                  start_o,
    input  logic                  adc_rdy_i,
    input  logic [RESOLUTION-1:0] adc_result_i,
    output logic [RESOLUTION-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic                  timeout_o
);
    localparam int ACC_W = RESOLUTION + LOG2_AVG;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_start;
    logic [PERIOD_W-1:0]   r_cnt_q;
    logic [TMO_W-1:0]      r_tmo;
    logic                  r_rdy_q;
    logic [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_cnt_s;
    logic [RESOLUTION-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_timeout;

    logic                  w_cap;
    logic                  w_last;
    logic                  w_done;
    logic                  w_tmo_hit;
    logic                  w_set_ovr;
    logic [PERIOD_W-1:0]   w_cnt_dec;
    logic [ACC_W-1:0]      w_sum;
    logic [RESOLUTION-1:0] w_avg;

    // Only a rising edge of rdy counts, so a level left high by the previous
    // conversion can never be captured twice.
    assign w_cap     = adc_rdy_i & ~r_rdy_q;
    assign w_last    = (r_cnt_s == LAST_SMP);
    assign w_done    = (r_state == CONV) && w_cap && en_i && w_last;
    assign w_tmo_hit = (r_state == CONV) && !w_cap && (r_tmo == TMO_LAST);
    assign w_set_ovr = w_done && r_valid && !ready_i;
    assign w_cnt_dec = (r_cnt_q == '0) ? '0 : r_cnt_q - PERIOD_W'(1);
    // acc never holds more than 2**LOG2_AVG-1 samples, so this sum cannot wrap.
    assign w_sum     = r_acc + ACC_W'(adc_result_i);
    assign w_avg     = RESOLUTION'(w_sum >> LOG2_AVG);

    assign start_o   = r_start;
    assign busy_o    = (r_state == CONV);
    assign data_o    = r_data;
    assign valid_o   = r_valid;
    assign overrun_o = r_overrun;
    assign timeout_o = r_timeout;

    // NOTE: every state register uses <= so all updates see the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_start   <= 1'b0;
            r_cnt_q   <= '0;
            r_tmo     <= '0;
            r_rdy_q   <= 1'b0;
            r_acc     <= '0;
            r_cnt_s   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_rdy_q <= adc_rdy_i;
            r_start <= 1'b0;
            r_cnt_q <= w_cnt_dec;

            case (r_state)
                IDLE: begin
                    if (!en_i) begin
                        r_acc   <= '0;
                        r_cnt_s <= '0;
                        r_cnt_q <= '0;
                    end else if (r_cnt_q == '0) begin
                        r_start <= 1'b1;
                        r_cnt_q <= period_i;
                        r_tmo   <= '0;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    if (w_cap) begin
                        r_state <= IDLE;
                        if (!en_i || w_last) begin
                            r_acc   <= '0;
                            r_cnt_s <= '0;
                        end else begin
                            r_acc   <= w_sum;
                            r_cnt_s <= r_cnt_s + CNT_W'(1);
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A handshake in the completion cycle frees the slot for the new average.
            if (w_done && (!r_valid || ready_i)) begin
                r_data  <= w_avg;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end

            r_overrun <= w_set_ovr | (r_overrun & ~clr_status_i);
            r_timeout <= w_tmo_hit | (r_timeout & ~clr_status_i);
        end
    end

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// Self-checking bench for adc_avg_sequencer: a behavioural ADC drives the DUT and a
// sample-list scoreboard predicts every average, the output slot and the overrun flag.
module tb_adc_avg_sequencer;
    localparam int RES  = 8;
    localparam int L2   = 2;
    localparam int PW   = 16;
    localparam int TMO  = 64;
    localparam int NAVG = 1 << L2;

    logic           clk_i        = 1'b0;
    logic           rst_ni       = 1'b0;
    logic           en_i         = 1'b0;
    logic [PW-1:0]  period_i     = '0;
    logic           clr_status_i = 1'b0;
    logic           adc_rdy_i    = 1'b0;
    logic [RES-1:0] adc_result_i = '0;
    logic           ready_i      = 1'b0;
    logic           start_o;
    logic [RES-1:0] data_o;
    logic           valid_o;
    logic           busy_o;
    logic           overrun_o;
    logic           timeout_o;

    adc_avg_sequencer #(
        .RESOLUTION(RES),
        .LOG2_AVG  (L2),
        .PERIOD_W  (PW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .period_i    (period_i),
        .clr_status_i(clr_status_i),
        .start_o     (start_o),
        .adc_rdy_i   (adc_rdy_i),
        .adc_result_i(adc_result_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard: samples accumulated so far, and the single output slot
    int smp[$];
    int vals[$];
    int gaps[$];
    bit exp_full    = 1'b0;
    int exp_val     = 0;
    bit exp_ovr     = 1'b0;
    int n_captured  = 0;

    // behavioural ADC and bookkeeping
    bit raise_next  = 1'b0;
    int cap_val     = 0;
    bit pend        = 1'b0;
    int cd          = 0;
    int delay       = 12;
    bit stale       = 1'b0;
    bit pulse_rdy_on_done = 1'b0;
    bit chk_en      = 1'b0;
    bit prev_busy   = 1'b0;
    bit prev_valid  = 1'b0;
    int cycle       = 0;
    int last_start  = 0;
    int start_cnt   = 0;
    int valid_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
    endtask

    // Predicts the effect of the coming rising edge from the current inputs.
    task automatic model_edge();
        bit comp;
        int s;
        comp = 1'b0;
        s    = 0;
        if (raise_next) begin
            raise_next = 1'b0;
            if (en_i) begin
                smp.push_back(cap_val);
                n_captured++;
                if (smp.size() == NAVG) begin
                    foreach (smp[i]) s += smp[i];
                    comp = 1'b1;
                    smp.delete();
                end
            end else begin
                smp.delete();
            end
        end
        if (comp && (!exp_full || ready_i)) begin
            exp_full = 1'b1;
            exp_val  = s >> L2;
            exp_ovr  = exp_ovr & !clr_status_i;
        end else if (comp) begin
            exp_ovr = 1'b1;
        end else begin
            if (exp_full && ready_i) exp_full = 1'b0;
            exp_ovr = exp_ovr & !clr_status_i;
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge clk_i);
        cycle++;
        if (chk_en) begin
            check("valid_o", valid_o, exp_full);
            if (exp_full) check("data_o", data_o, exp_val);
            check("overrun_o", overrun_o, exp_ovr);
        end
        if (valid_o && !prev_valid) valid_pulses++;
        prev_valid = valid_o;
        if (start_o) begin
            check("start_in_conv", prev_busy, 0);
            gaps.push_back(cycle - last_start);
            last_start = cycle;
            start_cnt++;
            if (!stale) begin
                adc_rdy_i = 1'b0;
                pend      = 1'b1;
                cd        = delay;
            end
        end
        prev_busy = busy_o;
        if (pend) begin
            cd--;
            if (cd == 0) begin
                pend = 1'b0;
                cap_val = (vals.size() > 0) ? vals.pop_front() : int'($urandom_range(0, (1 << RES) - 1));
                adc_result_i = RES'(cap_val);
                adc_rdy_i    = 1'b1;
                raise_next   = 1'b1;
                if (pulse_rdy_on_done && en_i && smp.size() == NAVG - 1) begin
                    ready_i = 1'b1;
                    pulse_rdy_on_done = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_captures(input int n);
        int target;
        target = n_captured + n;
        for (int i = 0; i < 3000 && n_captured < target; i++) step();
        if (n_captured < target) check("capture_wait_expired", n_captured, target);
    endtask

    task automatic wait_starts(input int n);
        int target;
        target = start_cnt + n;
        for (int i = 0; i < 3000 && start_cnt < target; i++) step();
        if (start_cnt < target) check("start_wait_expired", start_cnt, target);
    endtask

    // Disable long enough for any conversion to resolve, drain the output, clear flags.
    task automatic quiesce();
        en_i    = 1'b0;
        ready_i = 1'b1;
        stale   = 1'b0;
        repeat (80) step();
        clr_status_i = 1'b1;
        step();
        clr_status_i = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},   start_o,   0);
        check({tag, "_valid"},   valid_o,   0);
        check({tag, "_busy"},    busy_o,    0);
        check({tag, "_data"},    data_o,    0);
        check({tag, "_overrun"}, overrun_o, 0);
        check({tag, "_timeout"}, timeout_o, 0);
    endtask

    initial begin
        int s0;
        int base_pulses;

        // reset state
        #23;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk_en = 1'b1;
        step();
        check("idle_no_start", start_o, 0);

        // averaging and nominal pacing: 21-cycle start spacing
        period_i = PW'(20);
        delay    = 12;
        ready_i  = 1'b1;
        vals     = '{10, 20, 30, 41};
        gaps.delete();
        valid_pulses = 0;
        en_i = 1'b1;
        wait_captures(4);
        check("avg_valid", valid_o, 1);
        check("avg_data", data_o, 25);
        for (int i = 1; i < gaps.size(); i++) check("gap_nominal", gaps[i], 21);
        repeat (30) step();
        check("avg_one_pulse", valid_pulses, 1);

        // slow conversion: next start one cycle after the capture
        delay = 30;
        gaps.delete();
        wait_starts(3);
        check("gap_slow_a", gaps[1], 31);
        check("gap_slow_b", gaps[2], 31);

        // randomized run with random backpressure and status clears
        for (int r = 0; r < 2000; r++) begin
            if (r % 150 == 0) begin
                period_i = PW'($urandom_range(0, 40));
                delay    = int'($urandom_range(2, 40));
            end
            ready_i      = ($urandom_range(0, 3) != 0);
            clr_status_i = ($urandom_range(0, 15) == 0);
            step();
        end
        clr_status_i = 1'b0;

        // backpressure: second average dropped, then handshake on the completion cycle
        quiesce();
        vals     = '{100, 101, 102, 103, 7, 7, 7, 7};
        ready_i  = 1'b0;
        delay    = 12;
        period_i = PW'(20);
        en_i     = 1'b1;
        wait_captures(8);
        vals = '{200, 200, 200, 203};
        check("bp_valid", valid_o, 1);
        check("bp_data_held", data_o, 101);
        check("bp_overrun", overrun_o, 1);
        clr_status_i = 1'b1;
        step();
        clr_status_i = 1'b0;
        check("bp_clr", overrun_o, 0);
        pulse_rdy_on_done = 1'b1;
        wait_captures(4);
        ready_i = 1'b0;
        check("bp_new_valid", valid_o, 1);
        check("bp_new_data", data_o, 200);
        check("bp_no_overrun", overrun_o, 0);

        // stale ready: timeout 64 cycles after start, accumulated samples kept
        quiesce();
        vals    = '{40, 50, 60, 70};
        ready_i = 1'b1;
        en_i    = 1'b1;
        wait_captures(2);
        stale = 1'b1;
        wait_starts(1);
        s0 = last_start;
        for (int i = 0; i < 200 && !timeout_o; i++) step();
        check("stale_timeout", timeout_o, 1);
        check("stale_latency", cycle - s0, 64);
        stale = 1'b0;
        wait_captures(2);
        check("stale_acc_kept", data_o, 55);
        check("stale_flag_held", timeout_o, 1);
        clr_status_i = 1'b1;
        step();
        clr_status_i = 1'b0;
        check("timeout_clr", timeout_o, 0);

        // enable drop mid-conversion after 2 of 4 samples
        quiesce();
        vals    = '{1, 2, 99, 10, 20, 30, 40};
        ready_i = 1'b1;
        en_i    = 1'b1;
        wait_captures(2);
        wait_starts(1);
        repeat (3) step();
        en_i = 1'b0;
        base_pulses = valid_pulses;
        repeat (30) step();
        check("drop_no_output", valid_pulses - base_pulses, 0);
        en_i = 1'b1;
        wait_captures(4);
        check("drop_fresh_avg", data_o, 25);

        // asynchronous reset during CONV with valid_o high
        quiesce();
        ready_i = 1'b0;
        en_i    = 1'b1;
        wait_captures(4);
        wait_starts(1);
        check("pre_rst_busy", busy_o, 1);
        check("pre_rst_valid", valid_o, 1);
        chk_en = 1'b0;
        #3 rst_ni = 1'b0;
        #1;
        check_all_zero("async_rst");
        smp.delete();
        exp_full   = 1'b0;
        exp_ovr    = 1'b0;
        raise_next = 1'b0;
        pend       = 1'b0;
        adc_rdy_i  = 1'b0;
        prev_busy  = 1'b0;
        prev_valid = 1'b0;
        en_i       = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk_en = 1'b1;
        repeat (3) begin
            step();
            check("post_rst_no_start", start_o, 0);
        end
        en_i = 1'b1;
        step();
        check("post_rst_first_start", start_o, 1);
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
